booth_mul_seq: RTL
==================

# booth_mul_seq

Sequential radix-4 Booth multiplier for the CPU datapath's MUL instruction, parametrised in operand width and supporting signed and unsigned operands. It retires one recoded Booth digit per clock, uses a start/done handshake, and holds the 2·WIDTH-bit product until the next operation. The control unit drives it, and the result feeds the HI/LO register pair.

## Interface
- WIDTH, 32, operand width in bits; must be even and ≥ 4
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- a  in  WIDTH  multiplicand; sampled with start
- b  in  WIDTH  multiplier; sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when product becomes valid
- product  out  2·WIDTH  result; held until the next accepted start

## Operation
- States: IDLE, RUN. No other states.
- IDLE, start=1: latch a and b extended to WIDTH+2 bits, sign-extended when is_signed=1, zero-extended otherwise.
  - Implicit bit below the multiplier LSB is 0.
  - Clear the accumulator and the digit counter.
  - Go to RUN.
- RUN: each cycle, recode bits (2i+1, 2i, 2i−1) of the extended multiplier into a digit d ∈ {−2,−1,0,+1,+2}.
  - Add d·a·4^i to the accumulator.
  - Arithmetic is at least 2·WIDTH+4 bits wide, with the multiplicand sign-extended.
- Recoding:
  - 000 and 111 → 0
  - 001 and 010 → +1
  - 011 → +2
  - 100 → −2
  - 101 and 110 → −1
- Digit count N = WIDTH/2 + 1, which covers the extension bits. After N digits:
  - product ← accumulator[2·WIDTH−1:0]
  - done pulses
  - return to IDLE
- start while busy=1 is ignored. Operands and mode cannot change mid-operation.
- Reset values: state IDLE, busy 0, done 0, product 0, internal registers 0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced and product reads 0.

## Timing
- Start accepted on rising edge k (state IDLE, start=1). busy=1 from cycle k+1.
- Digits are retired on edges k+1 … k+N.
- On edge k+N the block registers product, sets done=1 for exactly one cycle, and clears busy.
- Latency: N cycles from the start edge, which is 17 for WIDTH=32.
- Back-to-back: start may be asserted in the cycle where done=1, since the state is already IDLE. The new operation begins on the next edge, with no bubble beyond that.
- done and busy are never high together.

## Configuration
- BOOTH_MUL_EARLY_EXIT_EN defined: after each digit, if all unconsumed extended-multiplier bits plus the look-back bit are equal, every remaining digit is 0. The block then finishes on that edge.
  - Minimum one digit.
  - The product is identical to the full run.
  - Latency is in the range 1…N.
- Not defined: the block always runs exactly N digits, giving fixed latency.

## Structure
- Package booth_mul_pkg:
  - state enum (IDLE, RUN)
  - digit enum (ZERO, POS1, POS2, NEG1, NEG2)
  - function computing N from WIDTH
- Sub-module booth_r4_encoder: combinational, takes a 3-bit window and returns a digit enum. It is instantiated once and shared across iterations.

## Test plan
- WIDTH=32, is_signed=1, a=−3, b=7 → done 17 cycles after start; product=0xFFFFFFFF_FFFFFFEB.
- is_signed=0, a=b=0xFFFFFFFF → product=0xFFFFFFFE_00000001. The same operands with is_signed=1 → product=0x00000000_00000001.
- is_signed=1, a=b=0x80000000 → product=0x40000000_00000000. Extreme-negative case, covering the −2 digit with no overflow.
- Start (a=5, b=6); pulse start with a=9 at cycle 3 → ignored; product=30 at cycle 17. A new start during the done cycle yields the next result 17 cycles later.
- rst_n low at cycle 8 of an operation → busy, done and product read 0 at once. There is no done pulse, and the next operation computes correctly.
- With BOOTH_MUL_EARLY_EXIT_EN: b=1 → done after 1 cycle; b=0xFFFFFFFF signed → done after 1 cycle with product=−a. Random operands match the non-early-exit products.

Source files
------------

// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
`timescale 1ns/1ps
package booth_mul_pkg;

  // Controller states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Recoded radix-4 Booth digit
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_t;

  // Digits needed for a WIDTH-bit operand extended by two bits
  function automatic int calc_num_digits(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// to a signed digit in {-2,-1,0,+1,+2}.
`timescale 1ns/1ps
module booth_r4_encoder
  import booth_mul_pkg::*;
(
  input  logic [2:0] window,
  output digit_t     digit
);

  // Pure table lookup, no state
  always_comb begin
    digit = ZERO;
    case (window)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one recoded digit per clock.
// Optional macro BOOTH_MUL_EARLY_EXIT_EN: finish as soon as every remaining
// digit is known to be zero (latency 1..N instead of a fixed N).
`timescale 1ns/1ps
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int NUM_DIGITS = calc_num_digits(WIDTH);
  localparam int ACC_W      = 2 * WIDTH + 4;
  // Extended multiplier (WIDTH+2) plus the implicit look-back bit at the bottom
  localparam int MPL_W      = WIDTH + 3;
  localparam int CNT_W      = $clog2(NUM_DIGITS + 1);

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   mcand_reg;      // multiplicand pre-scaled by 4^i
  logic [MPL_W-1:0]   mplier_reg;     // window sits in bits [2:0]
  logic [ACC_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] product_reg;
  logic               done_reg;

  logic               a_fill, b_fill;
  logic [ACC_W-1:0]   mcand_init;
  logic [MPL_W-1:0]   mplier_init;
  logic [MPL_W-1:0]   mplier_shift;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   acc_next;
  logic               last_digit;
  logic               finish;
  digit_t             digit;

  assign a_fill      = is_signed & a[WIDTH-1];
  assign b_fill      = is_signed & b[WIDTH-1];
  assign mcand_init  = {{(ACC_W-WIDTH){a_fill}}, a};
  assign mplier_init = {{2{b_fill}}, b, 1'b0};

  // Arithmetic shift keeps the fill equal to the extended sign, so the
  // register remains a faithful view of the unconsumed bits.
  assign mplier_shift = {{2{mplier_reg[MPL_W-1]}}, mplier_reg[MPL_W-1:2]};
  assign last_digit   = (cnt_reg == CNT_W'(NUM_DIGITS - 1));

  booth_r4_encoder u_encoder (
    .window (mplier_reg[2:0]),
    .digit  (digit)
  );

  // Scale the current multiplicand by the recoded digit
  always_comb begin
    addend = '0;
    case (digit)
      POS1:    addend = mcand_reg;
      POS2:    addend = mcand_reg << 1;
      NEG1:    addend = -mcand_reg;
      NEG2:    addend = -(mcand_reg << 1);
      default: addend = '0;
    endcase
  end

  assign acc_next = acc_reg + addend;

`ifdef BOOTH_MUL_EARLY_EXIT_EN
  // Remaining digits are all zero when the unconsumed bits and look-back bit agree
  logic [MPL_W-2:0] bit_diff;
  genvar gi;
  generate
    for (gi = 0; gi < MPL_W - 1; gi++) begin : g_uniform
      assign bit_diff[gi] = mplier_shift[gi+1] ^ mplier_shift[gi];
    end
  endgenerate
  assign finish = last_digit | ~(|bit_diff);
`else
  assign finish = last_digit;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: accept start in IDLE, leave RUN after the final digit
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)  state_next = RUN;
      RUN:     if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the state
  always_comb begin
    busy = (state_reg == RUN);
  end

  // Datapath: latch operands on start, retire one digit per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg  <= mcand_init;
            mplier_reg <= mplier_init;
            acc_reg    <= '0;
            cnt_reg    <= '0;
          end
        end
        RUN: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 2;
          mplier_reg <= mplier_shift;
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (finish) begin
            product_reg <= acc_next[2*WIDTH-1:0];
            done_reg    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done    = done_reg;
  assign product = product_reg;

endmodule
